// File: rtl/pic_ack_sequencer_pkg.sv
// =============================================================================
// Module      : pic_pkg
// Description : Shared types and constants for the 8259 acknowledge sequencer.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package pic_pkg;

    localparam int IR_COUNT = 8;
    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK1 = 2'd2,
        ACK2 = 2'd3
    } pic_state_e;

    // Distance from the top of the rotating priority order; 0 is highest.
    function automatic logic [2:0] prio_rank(input logic [2:0] level,
                                             input logic [2:0] low_pri);
        return level - low_pri - 3'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pic_ack_sequencer_prio_resolver.sv
// =============================================================================
// Module      : pic_prio_resolver
// Description : Finds the highest-priority set bit under rotating priority.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module pic_prio_resolver
    import pic_pkg::*;
(
    input  logic [IR_COUNT-1:0] vec,
    input  logic [2:0]          low_pri,
    output logic                valid,
    output logic [2:0]          level
);

    logic [2:0] idx;

    // Walk from lowest to highest priority so the last hit wins.
    always_comb begin
        valid = 1'b0;
        level = 3'd0;
        idx   = 3'd0;
        for (int i = IR_COUNT - 1; i >= 0; i--) begin
            idx = low_pri + 3'(i + 1);
            if (vec[idx]) begin
                valid = 1'b1;
                level = idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pic_ack_sequencer.sv
// =============================================================================
// Module      : pic_ack_sequencer
// Description : 8259 interrupt resolution and two-pulse INTA handshake.
//               Optional macro PIC_AUTO_ROTATE_EN enables rotating priority.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module pic_ack_sequencer
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [IR_COUNT-1:0] IRR,
    input  logic                INTA_N,
    input  logic [4:0]          VEC_BASE,
    input  logic                AEOI,
    input  logic                EOI_STB,
    input  logic                EOI_SPECIFIC,
    input  logic [2:0]          EOI_LEVEL,
`ifdef PIC_AUTO_ROTATE_EN
    input  logic                ROTATE_ON_EOI,
`endif
    output logic                INT,
    output logic [IR_COUNT-1:0] ISR,
    output logic [IR_COUNT-1:0] IRR_CLR,
    output logic [7:0]          DATA_OUT,
    output logic                DATA_OE
);

    pic_state_e          state_q, state_d;
    logic [IR_COUNT-1:0] isr_q, isr_d;
    logic [IR_COUNT-1:0] irr_clr_q, irr_clr_d;
    logic [7:0]          data_out_q, data_out_d;
    logic                data_oe_q, data_oe_d;
    logic [2:0]          level_q, level_d;
    logic                spurious_q, spurious_d;
    logic [2:0]          low_pri_q;
    logic                inta_prev_q;
    logic                w_inta_s;

    logic                w_irr_vld, w_isr_vld, w_cand_vld;
    logic [2:0]          w_irr_lvl, w_isr_lvl;
    logic                w_fall, w_rise;
    logic [2:0]          w_eoi_target;
    logic                w_eoi_hit;
    logic [IR_COUNT-1:0] w_eoi_clr, w_aeoi_clr, w_isr_set;

`ifdef PIC_AUTO_ROTATE_EN
    logic [2:0] low_pri_d;
`else
    assign low_pri_q = 3'd7;
`endif

    generate
        if (SYNC_STAGES == 2) begin : g_sync2
            logic sync1_q, sync2_q;
            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                end else begin
                    sync1_q <= INTA_N;
                    sync2_q <= sync1_q;
                end
            end
            assign w_inta_s = sync2_q;
        end else begin : g_sync0
            assign w_inta_s = INTA_N;
        end
    endgenerate

    assign w_fall = inta_prev_q & ~w_inta_s;
    assign w_rise = ~inta_prev_q & w_inta_s;

    pic_prio_resolver u_irr_res (
        .vec     (IRR),
        .low_pri (low_pri_q),
        .valid   (w_irr_vld),
        .level   (w_irr_lvl)
    );

    pic_prio_resolver u_isr_res (
        .vec     (isr_q),
        .low_pri (low_pri_q),
        .valid   (w_isr_vld),
        .level   (w_isr_lvl)
    );

    // Strictly-above comparison blocks both lower levels and self-nesting.
    assign w_cand_vld = w_irr_vld &&
        (!w_isr_vld || (prio_rank(w_irr_lvl, low_pri_q) < prio_rank(w_isr_lvl, low_pri_q)));

    assign w_eoi_target = EOI_SPECIFIC ? EOI_LEVEL : w_isr_lvl;
    assign w_eoi_hit    = EOI_STB && (EOI_SPECIFIC ? isr_q[EOI_LEVEL] : w_isr_vld);

    always_comb begin
        state_d    = state_q;
        irr_clr_d  = '0;
        data_out_d = data_out_q;
        data_oe_d  = data_oe_q;
        level_d    = level_q;
        spurious_d = spurious_q;
        w_eoi_clr  = '0;
        w_aeoi_clr = '0;
        w_isr_set  = '0;
`ifdef PIC_AUTO_ROTATE_EN
        low_pri_d  = low_pri_q;
`endif

        if (w_eoi_hit) begin
            w_eoi_clr = 8'b1 << w_eoi_target;
`ifdef PIC_AUTO_ROTATE_EN
            if (ROTATE_ON_EOI) low_pri_d = w_eoi_target;
`endif
        end

        case (state_q)
            IDLE: begin
                if (w_cand_vld) state_d = REQ;
            end
            REQ: begin
                if (w_fall) begin
                    state_d = ACK1;
                    if (w_cand_vld) begin
                        level_d    = w_irr_lvl;
                        spurious_d = 1'b0;
                        w_isr_set  = 8'b1 << w_irr_lvl;
                        irr_clr_d  = 8'b1 << w_irr_lvl;
                    end else begin
                        level_d    = SPURIOUS_LEVEL;
                        spurious_d = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (w_fall) begin
                    state_d    = ACK2;
                    data_oe_d  = 1'b1;
                    data_out_d = {VEC_BASE, level_q};
                end
            end
            ACK2: begin
                if (w_rise) begin
                    state_d   = IDLE;
                    data_oe_d = 1'b0;
                    if (AEOI && !spurious_q) begin
                        w_aeoi_clr = 8'b1 << level_q;
`ifdef PIC_AUTO_ROTATE_EN
                        if (ROTATE_ON_EOI) low_pri_d = level_q;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Clears land before the ACK1 set, so a colliding bit stays set.
        isr_d = (isr_q & ~w_eoi_clr & ~w_aeoi_clr) | w_isr_set;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            isr_q       <= '0;
            irr_clr_q   <= '0;
            data_out_q  <= '0;
            data_oe_q   <= 1'b0;
            level_q     <= 3'd0;
            spurious_q  <= 1'b0;
            inta_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            isr_q       <= isr_d;
            irr_clr_q   <= irr_clr_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
            level_q     <= level_d;
            spurious_q  <= spurious_d;
            inta_prev_q <= w_inta_s;
        end
    end

`ifdef PIC_AUTO_ROTATE_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) low_pri_q <= 3'd7;
        else        low_pri_q <= low_pri_d;
    end
`endif

    assign INT      = (state_q == REQ);
    assign ISR      = isr_q;
    assign IRR_CLR  = irr_clr_q;
    assign DATA_OUT = data_out_q;
    assign DATA_OE  = data_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_pic_ack_sequencer.sv
// =============================================================================
// Module      : tb_pic_ack_sequencer
// Description : Directed self-checking bench for pic_ack_sequencer.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_pic_ack_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irr = 8'h00;
    logic       inta_n = 1'b1;
    logic [4:0] vec_base = 5'h08;
    logic       aeoi = 1'b0;
    logic       eoi_stb = 1'b0;
    logic       eoi_specific = 1'b0;
    logic [2:0] eoi_level = 3'd0;
`ifdef PIC_AUTO_ROTATE_EN
    logic       rotate_on_eoi = 1'b0;
`endif
    logic       int_o;
    logic [7:0] isr, irr_clr, data_out;
    logic       data_oe;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pic_ack_sequencer #(.SYNC_STAGES(2)) dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .IRR          (irr),
        .INTA_N       (inta_n),
        .VEC_BASE     (vec_base),
        .AEOI         (aeoi),
        .EOI_STB      (eoi_stb),
        .EOI_SPECIFIC (eoi_specific),
        .EOI_LEVEL    (eoi_level),
`ifdef PIC_AUTO_ROTATE_EN
        .ROTATE_ON_EOI(rotate_on_eoi),
`endif
        .INT          (int_o),
        .ISR          (isr),
        .IRR_CLR      (irr_clr),
        .DATA_OUT     (data_out),
        .DATA_OE      (data_oe)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Pin change, two sync flops, then the state update edge.
    task automatic inta_drive(input logic v);
        inta_n = v;
        cyc(3);
    endtask

    task automatic eoi(input logic spec, input logic [2:0] lvl);
        eoi_stb = 1'b1; eoi_specific = spec; eoi_level = lvl;
        cyc(1);
        eoi_stb = 1'b0; eoi_specific = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        cyc(2);
        check("rst_int", {7'd0, int_o}, 8'h00);
        check("rst_isr", isr, 8'h00);
        check("rst_irrclr", irr_clr, 8'h00);
        check("rst_dout", data_out, 8'h00);
        check("rst_doe", {7'd0, data_oe}, 8'h00);
        rst_n = 1'b1;
        cyc(1);

        // INTA in IDLE is ignored
        inta_drive(1'b0);
        inta_drive(1'b1);
        check("idle_inta_isr", isr, 8'h00);
        check("idle_inta_doe", {7'd0, data_oe}, 8'h00);

        // Basic IR2 acknowledge
        irr = 8'h04;
        cyc(1);
        check("t1_int", {7'd0, int_o}, 8'h01);
        inta_drive(1'b0);
        check("t1_isr", isr, 8'h04);
        check("t1_irrclr", irr_clr, 8'h04);
        check("t1_int_fall", {7'd0, int_o}, 8'h00);
        irr = 8'h00;
        cyc(1);
        check("t1_irrclr_pulse", irr_clr, 8'h00);
        inta_drive(1'b1);
        check("t1_doe_between", {7'd0, data_oe}, 8'h00);
        inta_drive(1'b0);
        check("t1_doe", {7'd0, data_oe}, 8'h01);
        check("t1_dout", data_out, 8'h42);
        inta_drive(1'b1);
        check("t1_doe_off", {7'd0, data_oe}, 8'h00);
        check("t1_isr_kept", isr, 8'h04);

        // Lower-priority IR4 is blocked by IR2 in service; IR0 nests
        irr = 8'h10;
        cyc(3);
        check("t2_blocked", {7'd0, int_o}, 8'h00);
        irr = 8'h11;
        cyc(1);
        check("t2_int", {7'd0, int_o}, 8'h01);
        inta_drive(1'b0);
        check("t2_isr", isr, 8'h05);
        check("t2_irrclr", irr_clr, 8'h01);
        irr = 8'h10;
        inta_drive(1'b1);
        inta_drive(1'b0);
        check("t2_dout", data_out, 8'h40);
        inta_drive(1'b1);
        irr = 8'h00;
        eoi(1'b0, 3'd0);
        check("t2_ns_eoi", isr, 8'h04);
        eoi(1'b1, 3'd2);
        check("t2_sp_eoi", isr, 8'h00);
        eoi(1'b0, 3'd0);
        check("t2_ns_eoi_empty", isr, 8'h00);

        // Spurious: request withdrawn before INTA
        irr = 8'h08;
        cyc(1);
        irr = 8'h00;
        cyc(3);
        check("t3_int_held", {7'd0, int_o}, 8'h01);
        inta_drive(1'b0);
        check("t3_isr", isr, 8'h00);
        check("t3_irrclr", irr_clr, 8'h00);
        inta_drive(1'b1);
        inta_drive(1'b0);
        check("t3_dout", data_out, 8'h47);
        inta_drive(1'b1);

        // AEOI on IR3
        aeoi = 1'b1;
        irr = 8'h08;
        cyc(1);
        inta_drive(1'b0);
        check("t4_isr_set", isr, 8'h08);
        irr = 8'h00;
        inta_drive(1'b1);
        inta_drive(1'b0);
        check("t4_dout", data_out, 8'h43);
        check("t4_isr_mid", isr, 8'h08);
        inta_drive(1'b1);
        check("t4_isr_aeoi", isr, 8'h00);
        aeoi = 1'b0;

        // EOI colliding with the ACK1 set of the same bit
        irr = 8'h02;
        cyc(1);
        inta_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        eoi_stb = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd1;
        cyc(1);
        eoi_stb = 1'b0; eoi_specific = 1'b0;
        check("t5_collide", isr, 8'h02);
        irr = 8'h00;
        inta_drive(1'b1);
        inta_drive(1'b0);
        inta_drive(1'b1);
        eoi(1'b1, 3'd1);
        check("t5_clear", isr, 8'h00);

`ifdef PIC_AUTO_ROTATE_EN
        rotate_on_eoi = 1'b1;
        irr = 8'h04;
        cyc(1);
        inta_drive(1'b0);
        irr = 8'h00;
        inta_drive(1'b1);
        inta_drive(1'b0);
        inta_drive(1'b1);
        eoi(1'b0, 3'd0);
        check("t6_rot_eoi", isr, 8'h00);
        irr = 8'h0A;
        cyc(1);
        inta_drive(1'b0);
        check("t6_rot_first", irr_clr, 8'h08);
        irr = 8'h02;
        inta_drive(1'b1);
        inta_drive(1'b0);
        check("t6_rot_vec", data_out, 8'h43);
        inta_drive(1'b1);
        eoi(1'b0, 3'd0);
        cyc(1);
        inta_drive(1'b0);
        check("t6_rot_second", isr, 8'h02);
        irr = 8'h00;
        inta_drive(1'b1);
        inta_drive(1'b0);
        inta_drive(1'b1);
        eoi(1'b0, 3'd0);
        rotate_on_eoi = 1'b0;
`endif

        // Reset during ACK2
        irr = 8'h02;
        cyc(1);
        inta_drive(1'b0);
        irr = 8'h00;
        inta_drive(1'b1);
        inta_drive(1'b0);
        check("t7_doe_pre", {7'd0, data_oe}, 8'h01);
        rst_n = 1'b0;
        inta_n = 1'b1;
        cyc(1);
        check("t7_doe", {7'd0, data_oe}, 8'h00);
        check("t7_isr", isr, 8'h00);
        check("t7_int", {7'd0, int_o}, 8'h00);
        check("t7_dout", data_out, 8'h00);
        rst_n = 1'b1;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
